vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder_if.sv | 23 ++
 rtl/vga_sync_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder_if.sv
// Interface for the VGA sync decoder: sync inputs from the video source
// and timing measurements back out.
interface vga_sync_decoder_if;
  logic        hsync;
  logic        vsync;
  logic [11:0] col;
  logic [10:0] row;
  logic [11:0] line_len;
  logic [11:0] hs_width;
  logic [10:0] frame_lines;
  logic        new_frame;
  logic        locked;

  modport master (
    output hsync, vsync,
    input  col, row, line_len, hs_width, frame_lines, new_frame, locked
  );

  modport slave (
    input  hsync, vsync,
    output col, row, line_len, hs_width, frame_lines, new_frame, locked
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// Measures VGA line/frame timing from async sync pins and tracks lock.
// Optional loss-of-signal watchdog: define VGA_DEC_TIMEOUT_EN.
module vga_sync_decoder #(
  parameter int unsigned LOCK_LINES = 4,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic             clock,
  input  logic             reset,
  vga_sync_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_LINE_OK = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

`ifdef VGA_DEC_TIMEOUT_EN
  localparam logic WDOG_EN = 1'b1;
`else
  localparam logic WDOG_EN = 1'b0;
`endif

  localparam logic [11:0] TIMEOUT_M1  = 12'(TIMEOUT - 1);
  localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_LINES - 1);

  logic        r_hs_meta, r_hs_sync, r_hs_prev;
  logic        r_vs_meta, r_vs_sync, r_vs_prev;
  logic [11:0] r_col, r_line_len, r_hs_cnt, r_hs_width;
  logic [10:0] r_row, r_frame_lines;
  logic        r_new_frame, r_locked;
  logic [2:0]  r_match_cnt;
  state_t      r_state;

  logic        w_hs_fall, w_hs_rise, w_vs_fall;
  logic [12:0] w_len_meas;
  logic [11:0] w_frm_meas;
  logic        w_line_match, w_frame_match, w_timeout;
  logic [3:0]  w_cnt_inc;
  logic [2:0]  w_match_cnt_nxt;
  state_t      w_state_nxt;
  logic        w_locked_nxt;

  // Sync pins idle high, so presetting the flops to 1 avoids a false edge after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_hs_meta <= 1'b1;
      r_hs_sync <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs_meta <= bus.hsync;
      r_hs_sync <= r_hs_meta;
      r_hs_prev <= r_hs_sync;
      r_vs_meta <= bus.vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_hs_fall     = r_hs_prev & ~r_hs_sync;
  assign w_hs_rise     = ~r_hs_prev & r_hs_sync;
  assign w_vs_fall     = r_vs_prev & ~r_vs_sync;
  assign w_len_meas    = {1'b0, r_col} + 13'd1;
  assign w_frm_meas    = {1'b0, r_row} + 12'd1;
  assign w_line_match  = (w_len_meas == {1'b0, r_line_len});
  assign w_frame_match = (w_frm_meas == {1'b0, r_frame_lines});
  assign w_cnt_inc     = {1'b0, r_match_cnt} + 4'd1;
  assign w_timeout     = WDOG_EN && !w_hs_fall && (r_col == TIMEOUT_M1);

  // Position counters and measurements; the watchdog clear overrides fresh loads.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_col         <= 12'd0;
      r_row         <= 11'd0;
      r_line_len    <= 12'd0;
      r_frame_lines <= 11'd0;
      r_new_frame   <= 1'b0;
      r_hs_cnt      <= 12'd0;
      r_hs_width    <= 12'd0;
    end else begin
      if (w_hs_fall) begin
        r_col      <= 12'd0;
        r_line_len <= w_len_meas[11:0];
      end else if (r_col != 12'hFFF) begin
        r_col <= r_col + 12'd1;
      end
      if (w_vs_fall) begin
        r_row         <= 11'd0;
        r_frame_lines <= w_frm_meas[10:0];
        r_new_frame   <= 1'b1;
      end else begin
        r_new_frame <= 1'b0;
        if (w_hs_fall && (r_row != 11'h7FF)) begin
          r_row <= r_row + 11'd1;
        end
      end
      if (!r_hs_sync) begin
        if (r_hs_cnt != 12'hFFF) begin
          r_hs_cnt <= r_hs_cnt + 12'd1;
        end
      end else begin
        r_hs_cnt <= 12'd0;
      end
      if (w_hs_rise) begin
        r_hs_width <= r_hs_cnt;
      end
      if (w_timeout) begin
        r_line_len    <= 12'd0;
        r_frame_lines <= 11'd0;
      end
    end
  end

  // State register, match counter and registered lock flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_SEARCH;
      r_match_cnt <= 3'd0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_locked    <= w_locked_nxt;
    end
  end

  // Next-state logic; LOCK_LINES equal lengths means LOCK_LINES-1 successive matches.
  always_comb begin
    w_state_nxt     = r_state;
    w_match_cnt_nxt = r_match_cnt;
    case (r_state)
      ST_SEARCH: begin
        if (w_hs_fall) begin
          if (w_line_match) begin
            w_match_cnt_nxt = (r_match_cnt == 3'd7) ? 3'd7 : w_cnt_inc[2:0];
            if (w_cnt_inc >= LOCK_TARGET) begin
              w_state_nxt = ST_LINE_OK;
            end else begin
              w_state_nxt = ST_SEARCH;
            end
          end else begin
            w_match_cnt_nxt = 3'd0;
          end
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_LINE_OK: begin
        if (w_hs_fall && !w_line_match) begin
          w_state_nxt     = ST_SEARCH;
          w_match_cnt_nxt = 3'd0;
        end else if (w_vs_fall && w_frame_match && (r_frame_lines != 11'd0)) begin
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_LINE_OK;
        end
      end
      ST_LOCKED: begin
        if ((w_hs_fall && !w_line_match) || (w_vs_fall && !w_frame_match)) begin
          w_state_nxt     = ST_SEARCH;
          w_match_cnt_nxt = 3'd0;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt     = ST_SEARCH;
        w_match_cnt_nxt = 3'd0;
      end
    endcase
    if (w_timeout) begin
      w_state_nxt     = ST_SEARCH;
      w_match_cnt_nxt = 3'd0;
    end else begin
      w_state_nxt     = w_state_nxt;
    end
  end

  // Output decode from the next state so locked lands one cycle after the deciding event.
  always_comb begin
    w_locked_nxt = 1'b0;
    if (w_state_nxt == ST_LOCKED) begin
      w_locked_nxt = 1'b1;
    end else begin
      w_locked_nxt = 1'b0;
    end
  end

  assign bus.col         = r_col;
  assign bus.row         = r_row;
  assign bus.line_len    = r_line_len;
  assign bus.hs_width    = r_hs_width;
  assign bus.frame_lines = r_frame_lines;
  assign bus.new_frame   = r_new_frame;
  assign bus.locked      = r_locked;

endmodule
